// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two bytes through a byte UART
// (high byte first), then waits for a single response byte. If no response
// arrives within TIMEOUT_CYCLES it aborts the wait and flags a timeout.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   send_cmd, cmd[15:0]   request to send cmd; accepted only when idle
//   busy                  high whenever a transaction is in progress
//   cmd_sent              both command bytes have been transmitted
//   resp_rdy, resp[7:0]   response byte held; cleared by clr_resp_rdy
//   timeout               last transaction got no response in time
//   trmt, tx_data[7:0]    transmit strobe and byte to the UART
//   tx_done               UART transmitter idle / byte finished
//   rx_rdy, rx_data[7:0]  received byte from the UART
//   clr_rx_rdy            consume or flush the UART receive byte
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for send_cmd
// SEND_HI   | trmt high with the high command byte, stale rx flushed
// WAIT_HI   | waiting for the UART to finish the high byte
// SEND_LO   | trmt high with the low command byte
// WAIT_LO   | waiting for the UART to finish the low byte
// WAIT_RESP | waiting for a response byte, timeout counter running
module remote_comm #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_cmd,
  input  logic [15:0] cmd,
  output logic        busy,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  input  logic        clr_resp_rdy,
  output logic        timeout,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_HI   = 3'd1,
    WAIT_HI   = 3'd2,
    SEND_LO   = 3'd3,
    WAIT_LO   = 3'd4,
    WAIT_RESP = 3'd5
  } state_t;

  state_t           state;
  logic [7:0]       cmd_lo;  // high byte goes straight into tx_data
  logic [CNT_W-1:0] cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_lo     <= 8'h00;
      cnt        <= '0;
      cmd_sent   <= 1'b0;
      resp_rdy   <= 1'b0;
      resp       <= 8'h00;
      timeout    <= 1'b0;
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
      clr_rx_rdy <= 1'b0;
    end else begin
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
      // A set later in this block overrides the clear.
      if (clr_resp_rdy) resp_rdy <= 1'b0;

      case (state)
        IDLE: begin
          if (send_cmd) begin
            cmd_lo     <= cmd[7:0];
            cmd_sent   <= 1'b0;
            resp_rdy   <= 1'b0;
            timeout    <= 1'b0;
            trmt       <= 1'b1;
            tx_data    <= cmd[15:8];
            // If the response-consume pulse is still high (back-to-back
            // command), the byte is already consumed; skip the flush so the
            // strobe never stays high for two cycles.
            clr_rx_rdy <= !clr_rx_rdy;
            state      <= SEND_HI;
          end
        end
        SEND_HI: state <= WAIT_HI;
        WAIT_HI: begin
          if (tx_done) begin
            trmt    <= 1'b1;
            tx_data <= cmd_lo;
            state   <= SEND_LO;
          end
        end
        SEND_LO: state <= WAIT_LO;
        WAIT_LO: begin
          // rx_rdy deliberately ignored here; an early byte waits in the UART.
          if (tx_done) begin
            cmd_sent <= 1'b1;
            cnt      <= '0;
            state    <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (rx_rdy) begin
            resp       <= rx_data;
            resp_rdy   <= 1'b1;
            clr_rx_rdy <= 1'b1;
            state      <= IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
